// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, edge/bit counters, checker enables, frame result pulses.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int EDGE_CNT_WIDTH = 6,
   parameter int DATA_WIDTH     = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          RX_IN,
   input  logic [PRESCALE_WIDTH-1:0]     prescale,
   input  logic                          PAR_EN,
   input  logic                          strt_glitch,
   input  logic                          par_err,
   input  logic                          stp_err,
   output logic [EDGE_CNT_WIDTH-1:0]     edge_cnt,
   output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt,
   output logic                          dat_samp_en,
   output logic                          strt_chk_en,
   output logic                          par_chk_en,
   output logic                          stp_chk_en,
   output logic                          deser_en,
   output logic                          data_valid,
   output logic                          frame_err,
   output logic                          parity_err
);

   localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH);
   localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      DONE
   } state_t;

   state_t                    state_reg, state_next;
   logic [EDGE_CNT_WIDTH-1:0] edge_cnt_reg, edge_cnt_next;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt_reg, bit_cnt_next;
   logic                      stp_flag_reg, stp_flag_next;
   logic [EDGE_CNT_WIDTH-1:0] prescale_reg;
   logic [EDGE_CNT_WIDTH-1:0] last_edge, eval_edge, edge_inc;
   logic                      at_last, at_eval;

`ifdef UART_RX_PARITY_EN
   logic                      par_flag_reg, par_flag_next;
   logic                      par_en_reg;
`else
   logic                      unused_par;
   assign unused_par = PAR_EN ^ par_err;
`endif

   assign last_edge = prescale_reg - EDGE_CNT_WIDTH'(1);
   // Checkers register at (prescale/2)+2, so their result is readable one edge later.
   assign eval_edge = (prescale_reg >> 1) + EDGE_CNT_WIDTH'(3);
   assign at_last   = (edge_cnt_reg == last_edge);
   assign at_eval   = (edge_cnt_reg == eval_edge);
   assign edge_inc  = at_last ? '0 : edge_cnt_reg + EDGE_CNT_WIDTH'(1);

   assign edge_cnt = edge_cnt_reg;
   assign bit_cnt  = bit_cnt_reg;

   // Frame configuration is only taken between frames.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prescale_reg <= '0;
`ifdef UART_RX_PARITY_EN
         par_en_reg   <= 1'b0;
`endif
      end else if (state_reg == IDLE || state_reg == DONE) begin
         prescale_reg <= EDGE_CNT_WIDTH'(prescale);
`ifdef UART_RX_PARITY_EN
         par_en_reg   <= PAR_EN;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg    <= IDLE;
         edge_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         stp_flag_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_flag_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         edge_cnt_reg <= edge_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         stp_flag_reg <= stp_flag_next;
`ifdef UART_RX_PARITY_EN
         par_flag_reg <= par_flag_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      edge_cnt_next = edge_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      stp_flag_next = stp_flag_reg;
`ifdef UART_RX_PARITY_EN
      par_flag_next = par_flag_reg;
`endif
      dat_samp_en   = 1'b0;
      strt_chk_en   = 1'b0;
      par_chk_en    = 1'b0;
      stp_chk_en    = 1'b0;
      deser_en      = 1'b0;
      data_valid    = 1'b0;
      frame_err     = 1'b0;
      parity_err    = 1'b0;

      case (state_reg)
         IDLE: begin
            edge_cnt_next = '0;
            bit_cnt_next  = '0;
            stp_flag_next = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_next = 1'b0;
`endif
            if (!RX_IN) state_next = START;
         end
         START: begin
            dat_samp_en   = 1'b1;
            strt_chk_en   = 1'b1;
            edge_cnt_next = edge_inc;
            // A glitch abort wins even when the eval point is also the last edge.
            if (at_eval && strt_glitch) begin
               state_next    = IDLE;
               edge_cnt_next = '0;
               bit_cnt_next  = '0;
            end else if (at_last) begin
               state_next = DATA;
            end
         end
         DATA: begin
            dat_samp_en   = 1'b1;
            deser_en      = at_eval;
            edge_cnt_next = edge_inc;
            if (at_last) begin
               if (bit_cnt_reg == BIT_LAST) begin
                  bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                  state_next   = par_en_reg ? PARITY : STOP;
`else
                  state_next   = STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_CNT_WIDTH'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            dat_samp_en   = 1'b1;
            par_chk_en    = 1'b1;
            edge_cnt_next = edge_inc;
            if (at_eval) par_flag_next = par_err;
            if (at_last) state_next = STOP;
         end
`endif
         STOP: begin
            dat_samp_en   = 1'b1;
            stp_chk_en    = 1'b1;
            edge_cnt_next = edge_inc;
            if (at_eval) stp_flag_next = stp_err;
            if (at_last) state_next = DONE;
         end
         DONE: begin
            frame_err     = stp_flag_reg;
            stp_flag_next = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err    = par_flag_reg;
            data_valid    = !stp_flag_reg && !par_flag_reg;
            par_flag_next = 1'b0;
`else
            data_valid    = !stp_flag_reg;
`endif
            bit_cnt_next  = '0;
            // The DONE cycle already counts as edge 0 of a back-to-back start bit.
            if (!RX_IN) begin
               state_next    = START;
               edge_cnt_next = EDGE_CNT_WIDTH'(1);
            end else begin
               state_next    = IDLE;
               edge_cnt_next = '0;
            end
         end
         default: begin
            state_next    = IDLE;
            edge_cnt_next = '0;
            bit_cnt_next  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: per-frame vector table, cycle-exact decode model and
// a pulse scoreboard. Expectations follow the UART_RX_PARITY_EN build setting.
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
   localparam bit PB = 1'b1;
`else
   localparam bit PB = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       strt_glitch = 1'b0;
   logic       par_err = 1'b0;
   logic       stp_err = 1'b0;
   logic [5:0] edge_cnt;
   logic [2:0] bit_cnt;
   logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
   logic       data_valid, frame_err, parity_err;

   uart_rx_fsm #(
      .PRESCALE_WIDTH(6),
      .EDGE_CNT_WIDTH(6),
      .DATA_WIDTH(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .RX_IN(RX_IN),
      .prescale(prescale),
      .PAR_EN(PAR_EN),
      .strt_glitch(strt_glitch),
      .par_err(par_err),
      .stp_err(stp_err),
      .edge_cnt(edge_cnt),
      .bit_cnt(bit_cnt),
      .dat_samp_en(dat_samp_en),
      .strt_chk_en(strt_chk_en),
      .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en),
      .deser_en(deser_en),
      .data_valid(data_valid),
      .frame_err(frame_err),
      .parity_err(parity_err)
   );

   always #5 CLK = ~CLK;

   int cycle_count = 0;
   always @(posedge CLK) cycle_count <= cycle_count + 1;

   typedef struct {
      int         ps;
      bit         pe;
      logic [7:0] data;
      bit         par_inj;
      bit         stp_inj;
      bit         glitch;
      int         rst_bit;
      bit         chain;
      bit         cont;
      bit         exp_valid;
      bit         exp_perr;
      bit         exp_ferr;
      int         exp_deser;
      int         exp_done;
   } vec_t;

   typedef struct {
      int cyc;
      bit valid;
      bit perr;
      bit ferr;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycle_count);
      end
   endtask

   function automatic logic [16:0] out_vec();
      return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
              deser_en, data_valid, frame_err, parity_err};
   endfunction

   task automatic monitor();
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cycle_count) begin
         e = sb.pop_front();
         check("missing_pulse", cycle_count, e.cyc);
      end
      if (data_valid || parity_err || frame_err) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", int'({data_valid, parity_err, frame_err}), 0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", cycle_count, e.cyc);
            check("data_valid", int'(data_valid), int'(e.valid));
            check("parity_err", int'(parity_err), int'(e.perr));
            check("frame_err", int'(frame_err), int'(e.ferr));
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         monitor();
         RX_IN       = 1'b1;
         strt_glitch = 1'b0;
         par_err     = 1'b0;
         stp_err     = 1'b0;
      end
   endtask

   task automatic add(input int ps, input bit pe, input logic [7:0] data, input bit pi,
                      input bit si, input bit gl, input int rb, input bit ch, input bit ct,
                      input bit v, input bit pr, input bit fr, input int ds, input int dn);
      vec_t r;
      r = '{ps:ps, pe:pe, data:data, par_inj:pi, stp_inj:si, glitch:gl, rst_bit:rb,
            chain:ch, cont:ct, exp_valid:v, exp_perr:pr, exp_ferr:fr, exp_deser:ds, exp_done:dn};
      vecs.push_back(r);
   endtask

   task automatic run_frame(input vec_t r, input int idx);
      int s, P, pe_eff, E, D, rc, c_end;
      int mism, first_c, deser, pos, bi, st, e, b;
      logic [13:0] ev, first_act, first_exp;
      logic [16:0] ov;
      s      = r.cont ? 1 : 0;
      P      = r.ps;
      pe_eff = (r.pe && PB) ? 1 : 0;
      E      = P / 2 + 3;
      D      = (10 + pe_eff) * P + 1 - s;
      rc     = (r.rst_bit >= 0) ? (r.rst_bit + 1) * P + 3 - s : -1;
      c_end  = r.glitch ? E + 2 : ((rc > 0) ? rc : D);
      mism = 0; first_c = -1; deser = 0;
      first_act = '0; first_exp = '0;
      for (int c = s; c <= c_end; c++) begin
         @(negedge CLK);
         monitor();
         if (c == s && r.exp_done > 0)
            sb.push_back('{cyc:cycle_count - s + r.exp_done, valid:r.exp_valid,
                           perr:r.exp_perr, ferr:r.exp_ferr});
         // Expected decode for this cycle: 0 idle, 1 start, 2 data, 3 parity, 4 stop, 5 done.
         e = 0; b = 0;
         if (c == 0 || (r.glitch && c > E + 1)) st = 0;
         else if (c == D) st = 5;
         else begin
            pos = c - 1 + s;
            bi  = pos / P;
            e   = pos % P;
            if (bi == 0) st = 1;
            else if (bi <= 8) begin st = 2; b = bi - 1; end
            else if (bi == 9 && pe_eff == 1) st = 3;
            else st = 4;
         end
         ev = {6'(e), 3'(b), (st >= 1 && st <= 4), (st == 1), (st == 3), (st == 4),
               (st == 2 && e == E)};
         ov = out_vec();
         if (ov[16:3] != ev) begin
            if (mism == 0) begin first_c = c; first_act = ov[16:3]; first_exp = ev; end
            mism++;
         end
         if (deser_en) deser++;
         if (c == rc) begin
            RST = 1'b0;
            #1;
            check("reset_mid_frame_outputs", int'(out_vec()), 0);
         end else begin
            if (c == D) RX_IN = r.chain ? 1'b0 : 1'b1;
            else if (r.glitch) RX_IN = (c <= 2) ? 1'b0 : 1'b1;
            else if (c == 0) RX_IN = 1'b0;
            else begin
               bi = (c - 1 + s) / P;
               if (bi == 0) RX_IN = 1'b0;
               else if (bi <= 8) RX_IN = r.data[bi-1];
               else if (bi == 9 && pe_eff == 1) RX_IN = ^r.data;
               else RX_IN = 1'b1;
            end
            strt_glitch = r.glitch && (c == E + 1 - s);
            par_err     = r.par_inj && r.pe && (c == 9 * P + E + 1 - s);
            stp_err     = r.stp_inj && (c == (9 + pe_eff) * P + E + 1 - s);
            // Scramble configuration mid-frame; it must only be picked up in IDLE/DONE.
            if (!r.glitch && r.rst_bit < 0 && c >= 1 && c < D) begin
               prescale = (P == 8) ? 6'd32 : 6'd8;
               PAR_EN   = !r.pe;
            end else begin
               prescale = 6'(P);
               PAR_EN   = r.pe;
            end
         end
      end
      if (mism != 0)
         $display("  row %0d first decode diff at frame cycle %0d: got %h want %h",
                  idx, first_c, first_act, first_exp);
      check("decode_model", mism, 0);
      check("deser_count", deser, r.exp_deser);
      if (rc > 0) begin
         repeat (2) begin
            @(negedge CLK);
            monitor();
         end
         RST = 1'b1;
         idle(100);
      end
      $display("frame %0d ps=%0d pe=%0d glitch=%0d rst=%0d deser=%0d decode_diffs=%0d",
               idx, P, r.pe, r.glitch, (rc > 0), deser, mism);
   endtask

   initial begin
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_state", int'(out_vec()), 0);
      RST = 1'b1;
      idle(3);

      //   ps pe data   pi si gl rb  ch ct  v    perr fe deser done
      add(8,  0, 8'hA5, 0, 0, 0, -1, 0, 0, 1,   0,   0, 8, 81);
      add(16, 1, 8'h3C, 1, 0, 0, -1, 0, 0, !PB, PB,  0, 8, PB ? 177 : 161);
      add(8,  0, 8'h00, 0, 0, 1, -1, 0, 0, 0,   0,   0, 0, 0);
      add(8,  0, 8'h5A, 0, 1, 0, -1, 0, 0, 0,   0,   1, 8, 81);
      add(8,  0, 8'hC3, 0, 0, 0, -1, 1, 0, 1,   0,   0, 8, 81);
      add(8,  0, 8'h7E, 0, 0, 0, -1, 0, 1, 1,   0,   0, 8, 80);
      add(8,  0, 8'hFF, 0, 0, 0, 4,  0, 0, 0,   0,   0, 4, 0);
      add(8,  0, 8'h81, 0, 0, 0, -1, 0, 0, 1,   0,   0, 8, 81);
      add(32, 0, 8'h96, 0, 0, 0, -1, 0, 0, 1,   0,   0, 8, 321);
      add(16, 1, 8'hE7, 0, 0, 0, -1, 0, 0, 1,   0,   0, 8, PB ? 177 : 161);
      add(32, 1, 8'h18, 1, 1, 0, -1, 0, 0, 0,   PB,  1, 8, PB ? 353 : 321);
      add(16, 0, 8'h42, 0, 0, 0, -1, 0, 0, 1,   0,   0, 8, 161);

      foreach (vecs[i]) begin
         if (!vecs[i].cont) idle(3);
         run_frame(vecs[i], i);
      end
      idle(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-sequencing controller for the UART receive path. It detects the falling edge of a start bit and owns the oversampling edge counter and the data-bit counter. It drives the one-hot enables for the data sampler, start checker, parity checker, stop checker and deserializer, then collates their results into a single-cycle `data_valid` or error pulse per frame. It sits between the RX pin synchronizer and the per-bit checker blocks in the RX top level.

## Interface
- `PRESCALE_WIDTH`, 6, width of `prescale` input
- `EDGE_CNT_WIDTH`, 6, width of edge counter (must be ≥ `PRESCALE_WIDTH`)
- `DATA_WIDTH`, 8, data bits per frame (bit counter is `$clog2(DATA_WIDTH)` bits)
- `CLK`  in  1  receive oversampling clock
- `RST`  in  1  reset, asynchronous, active-low
- `RX_IN`  in  1  synchronized serial line, idle high
- `prescale`  in  `PRESCALE_WIDTH`  oversampling ratio; legal values 8, 16, 32
- `PAR_EN`  in  1  1 = frame carries a parity bit
- `strt_glitch`  in  1  start-checker result, valid one cycle at eval point
- `par_err`  in  1  parity-checker result, valid one cycle at eval point
- `stp_err`  in  1  stop-checker result, valid one cycle at eval point
- `edge_cnt`  out  `EDGE_CNT_WIDTH`  oversampling edge index within current bit
- `bit_cnt`  out  `$clog2(DATA_WIDTH)`  index of current data bit
- `dat_samp_en`  out  1  data sampler enable
- `strt_chk_en`  out  1  start checker enable
- `par_chk_en`  out  1  parity checker enable
- `stp_chk_en`  out  1  stop checker enable
- `deser_en`  out  1  deserializer shift strobe
- `data_valid`  out  1  frame received without error, one-cycle pulse
- `frame_err`  out  1  stop-bit error, one-cycle pulse
- `parity_err`  out  1  parity error, one-cycle pulse

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. State is registered; all outputs are registered or decoded from state plus `edge_cnt` only.
- Last edge: L = `prescale`−1. Eval point: E = (`prescale`>>1)+3. Checkers register their result at (`prescale`>>1)+2, so the result is visible at E.
- IDLE: `edge_cnt`=0, `bit_cnt`=0. When `RX_IN`=0 → START, with `edge_cnt`=0 on the next cycle.
- In every non-IDLE, non-DONE state, `edge_cnt` increments each cycle and wraps L→0 on the bit boundary.
- START: `strt_chk_en`=1. At E, if `strt_glitch`=1 → IDLE, with counters cleared and no output pulse. At L → DATA.
- DATA: `deser_en`=1 for exactly one cycle at edge E. At L, `bit_cnt` increments. When `bit_cnt`=`DATA_WIDTH`−1 at L: → PARITY if `PAR_EN`=1, else → STOP. `bit_cnt` wraps to 0.
- PARITY: `par_chk_en`=1. At E, latch `par_err` into an internal flag. At L → STOP.
- STOP: `stp_chk_en`=1. At E, latch `stp_err`. At L → DONE.
- DONE lasts one cycle and outputs:
  - `data_valid`=1 iff both latched flags are 0
  - `parity_err` = latched parity flag
  - `frame_err` = latched stop flag
  - Latched flags clear.
  - If `RX_IN`=0 → START with `edge_cnt` loaded to 1, which accounts for the DONE cycle. Else → IDLE.
- `dat_samp_en`=1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- `PAR_EN` and `prescale` are sampled in IDLE/DONE only; changes mid-frame are ignored until the next frame.
- Reset mid-frame returns to IDLE immediately. Latched error flags clear and no pulse is generated.

## Timing
- Reset values: state IDLE; `edge_cnt`, `bit_cnt` = 0; all enable and pulse outputs = 0.
- Frame length, start edge to DONE: (2 + `DATA_WIDTH` + `PAR_EN`)×`prescale` cycles, plus 1 cycle for DONE.
- `data_valid`, `frame_err` and `parity_err` are each high for exactly 1 cycle. `data_valid` is mutually exclusive with both error pulses.
- `deser_en` fires exactly `DATA_WIDTH` times per accepted frame.
- Glitch abort: the IDLE re-arm occurs on the cycle after E. A new start edge is accepted from the following IDLE cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, `par_chk_en`, `parity_err` and the parity latch exist as described.
- Not defined:
  - PARITY state is not compiled; DATA → STOP always.
  - `PAR_EN` and `par_err` are ignored.
  - `par_chk_en` and `parity_err` are tied 0.
  - Frame length is fixed at (2 + `DATA_WIDTH`)×`prescale` + 1.

## Test plan
- `prescale`=8, `PAR_EN`=0, frame 0xA5 with a good stop bit → 8 `deser_en` strobes at edge 7 of each data bit; `data_valid` pulse 81 cycles after the start edge; no error pulses.
- `prescale`=16, `PAR_EN`=1, checker drives `par_err`=1 at E of the parity bit → `parity_err`=1 and `data_valid`=0 in DONE; DONE occurs at cycle 177.
- `RX_IN` low for 3 cycles at `prescale`=8, with `strt_glitch`=1 at edge 7 → return to IDLE; zero `deser_en` strobes; no output pulse.
- `stp_err`=1 at E of the stop bit → `frame_err` one-cycle pulse; `data_valid`=0.
- Back-to-back frames with `RX_IN`=0 in DONE → next START begins with `edge_cnt`=1; second frame's `data_valid` arrives exactly 80 cycles (`prescale`=8, `PAR_EN`=0) after the first.
- `RST` asserted in DATA at `bit_cnt`=4 → all outputs 0 that cycle; no `data_valid` after release; next start edge is handled normally.
